// File: rtl/sum_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module   : sum_ascii_tx
// Function : binary value -> decimal ASCII line (double-dabble), MSD first,
//            leading zeros suppressed; SUM_ASCII_TX_CRLF_EN selects CR+LF.
// Revision : 1.0
// ============================================================================
module sum_ascii_tx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_DIGITS = 10,
  parameter logic [7:0]  TERM_CHAR  = 8'h0A
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] value_i,
  output logic              busy_o,
  output logic [7:0]        char_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              done_o
);

  localparam int unsigned c_ptr_w = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int unsigned c_cnt_w = $clog2(DATA_W + 1);
  localparam int unsigned c_bcd_w = 4 * MAX_DIGITS;
`ifdef SUM_ASCII_TX_CRLF_EN
  localparam logic [7:0] c_term_first = 8'h0D;
`else
  localparam logic [7:0] c_term_first = TERM_CHAR;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_EMIT    = 3'd2,
    S_TERM    = 3'd3,
`ifdef SUM_ASCII_TX_CRLF_EN
    S_TERM2   = 3'd4,
`endif
    S_DONE    = 3'd5
  } state_t;

  state_t               r_state, w_state;
  logic [c_bcd_w-1:0]   r_bcd, w_bcd;
  logic [DATA_W-1:0]    r_shift, w_shift;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt;
  logic [c_ptr_w-1:0]   r_ptr, w_ptr;
  logic [7:0]           r_char, w_char;
  logic                 r_valid, w_valid;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;

  logic [c_bcd_w-1:0]   w_bcd_adj;
  logic [c_bcd_w-1:0]   w_bcd_shl;
  logic [3:0]           w_nib [MAX_DIGITS];
  logic [c_ptr_w-1:0]   w_msd;
  logic [c_ptr_w-1:0]   w_ptr_dec;
  logic                 w_xfer;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_nib
    assign w_nib[gi] = r_bcd[4*gi +: 4];
    assign w_bcd_adj[4*gi +: 4] = (w_nib[gi] >= 4'd5) ? (w_nib[gi] + 4'd3) : w_nib[gi];
  end

  assign w_bcd_shl = {w_bcd_adj[c_bcd_w-2:0], r_shift[DATA_W-1]};
  assign w_ptr_dec = r_ptr - 1'b1;
  assign w_xfer    = r_valid & ready_i;

  // Index of the most significant nonzero digit; zero value gives index 0.
  always_comb begin
    w_msd = '0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (w_nib[k] != 4'd0) w_msd = c_ptr_w'(k);
    end
  end

  always_comb begin
    w_state = r_state;
    w_bcd   = r_bcd;
    w_shift = r_shift;
    w_cnt   = r_cnt;
    w_ptr   = r_ptr;
    w_char  = r_char;
    w_valid = r_valid;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_shift = value_i;
          w_bcd   = '0;
          w_cnt   = c_cnt_w'(DATA_W);
          w_state = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (r_cnt != '0) begin
          w_bcd   = w_bcd_shl;
          w_shift = r_shift << 1;
          w_cnt   = r_cnt - 1'b1;
        end else begin
          w_ptr   = w_msd;
          w_char  = 8'h30 + {4'h0, w_nib[w_msd]};
          w_valid = 1'b1;
          w_state = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_xfer) begin
          if (r_ptr == '0) begin
            w_char  = c_term_first;
            w_state = S_TERM;
          end else begin
            w_ptr  = w_ptr_dec;
            w_char = 8'h30 + {4'h0, w_nib[w_ptr_dec]};
          end
        end
      end
      S_TERM: begin
        if (w_xfer) begin
`ifdef SUM_ASCII_TX_CRLF_EN
          w_char  = 8'h0A;
          w_state = S_TERM2;
`else
          w_valid = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
`endif
        end
      end
`ifdef SUM_ASCII_TX_CRLF_EN
      S_TERM2: begin
        if (w_xfer) begin
          w_valid = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_bcd   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_bcd   <= w_bcd;
      r_shift <= w_shift;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
      r_char  <= w_char;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign busy_o  = r_busy;
  assign char_o  = r_char;
  assign valid_o = r_valid;
  assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sum_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_ascii_tx
// Function : randomized self-checking bench for sum_ascii_tx
// Revision : 1.0
// ============================================================================
module tb_sum_ascii_tx;

  localparam int unsigned DATA_W = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] value_i;
  logic        busy_o;
  logic [7:0]  char_o;
  logic        valid_o;
  logic        ready_i;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;
  byte unsigned exp_q[$];

  always #5 clk_i = ~clk_i;

  sum_ascii_tx #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(10),
    .TERM_CHAR (8'h0A)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .value_i(value_i),
    .busy_o (busy_o),
    .char_o (char_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .done_o (done_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: decimal digits by repeated division, then the terminator bytes.
  task automatic build_exp(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    exp_q.delete();
    if (t == 0) exp_q.push_back(8'h30);
    while (t != 0) begin
      exp_q.push_front(8'(8'h30 + (t % 10)));
      t = t / 10;
    end
`ifdef SUM_ASCII_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic run_line(input logic [31:0] v, input int ready_pct,
                          input int stall_first, input bit poke);
    byte unsigned got_q[$];
    int  cyc, first_k, done_k, stall_left, n;
    bit  prev_stall;
    logic [7:0] prev_char;
    build_exp(v);
    start_i = 1'b1;
    value_i = v;
    ready_i = 1'b0;
    step();
    start_i = 1'b0;
    check_val($sformatf("busy_after_start(%0d)", v), busy_o, 1);
    cyc = 0; first_k = -1; done_k = -1; stall_left = stall_first;
    prev_stall = 1'b0; prev_char = 8'h00;
    while (done_k < 0 && cyc < 400) begin
      cyc++;
      step();
      if (prev_stall) begin
        check_val("hold_valid", valid_o, 1);
        check_val("hold_char", char_o, prev_char);
      end
      if (valid_o && first_k < 0) begin
        first_k = cyc;
        check_val($sformatf("latency(%0d)", v), cyc, DATA_W + 1);
      end
      if (done_o) begin
        done_k = cyc;
        check_val("done_valid_low", valid_o, 0);
        check_val("done_busy_high", busy_o, 1);
      end
      if (valid_o && got_q.size() == 0 && stall_left > 0) begin
        ready_i = 1'b0;
        stall_left--;
      end else begin
        ready_i = ($urandom_range(1, 100) <= ready_pct);
      end
      if (valid_o && ready_i) got_q.push_back(char_o);
      prev_stall = valid_o && !ready_i;
      prev_char  = char_o;
      value_i    = $urandom;
      start_i    = poke && ($urandom_range(0, 2) == 0);
    end
    check_val($sformatf("done_seen(%0d)", v), done_k >= 0, 1);
    start_i = poke;
    step();
    start_i = 1'b0;
    check_val("busy_after_done", busy_o, 0);
    check_val("done_one_cycle", done_o, 0);
    check_val($sformatf("line_len(%0d)", v), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_val($sformatf("byte%0d(%0d)", i, v), got_q[i], exp_q[i]);
    if (ready_pct == 100 && stall_first == 0 && done_k >= 0)
      check_val($sformatf("back_to_back(%0d)", v), done_k - first_k, exp_q.size());
  endtask

  task automatic reset_mid_line();
    byte unsigned got_q[$];
    int cyc, seen;
    start_i = 1'b1;
    value_i = 32'd98765;
    ready_i = 1'b1;
    step();
    start_i = 1'b0;
    cyc = 0; seen = 0;
    while (seen < 3 && cyc < 100) begin
      cyc++;
      step();
      if (valid_o) begin
        seen++;
        got_q.push_back(char_o);
      end
    end
    check_val("rst_prefix_len", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check_val("rst_prefix0", got_q[0], 8'h39);
      check_val("rst_prefix1", got_q[1], 8'h38);
      check_val("rst_presented", got_q[2], 8'h37);
    end
    ready_i = 1'b0;
    rst_i   = 1'b1;
    step();
    rst_i   = 1'b0;
    ready_i = 1'b1;
    check_val("rst_valid", valid_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_char", char_o, 8'h00);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (valid_o || busy_o) seen++;
    end
    check_val("rst_no_resume", seen, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b0; value_i = '0;
    repeat (3) step();
    check_val("reset_busy", busy_o, 0);
    check_val("reset_valid", valid_o, 0);
    check_val("reset_done", done_o, 0);
    check_val("reset_char", char_o, 8'h00);
    rst_i = 1'b0;
    step();

    run_line(32'd142, 100, 0, 1'b0);
    run_line(32'd0, 100, 0, 1'b0);
    run_line(32'hFFFF_FFFF, 100, 0, 1'b0);
    run_line(32'd57, 100, 5, 1'b0);
    run_line(32'd1234, 100, 0, 1'b1);
    reset_mid_line();
    run_line(32'd7, 100, 0, 1'b0);
    run_line(32'd10, 60, 0, 1'b0);
    run_line(32'd1_000_000_000, 100, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      run_line(v, $urandom_range(40, 100), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
